// File: rtl/blink_pkg.sv
// Shared types and constants for the millisecond blink blocks (generator and meter).
package blink_pkg;

  localparam int unsigned MS_DIV_100MHZ = 100000;

  typedef logic [15:0] speed_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    TRACK = 2'd2
  } meter_state_t;

endpackage

// File: rtl/blink_meter_tic_gen.sv
// Millisecond prescaler: counts 0..TIC_DIV-1 and raises tic_o for the single clk in which it wraps.
module tic_gen
  import blink_pkg::*;
#(
  parameter int unsigned TIC_DIV = MS_DIV_100MHZ
) (
  input  logic clk,
  input  logic rst_n,
  output logic tic_o
);

  localparam int unsigned CNT_W = (TIC_DIV > 1) ? $clog2(TIC_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIC_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
  assign tic_o = (cnt_q == LAST);

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/blink_meter.sv
// Measures the half-period of a blink waveform in ms tics and reports it on the generator's speed scale.
// Optional glitch filter on the synchronized input: define BLINK_METER_GLITCH_FILTER_EN.
module blink_meter
  import blink_pkg::*;
#(
  parameter int unsigned TIC_DIV       = MS_DIV_100MHZ,
  parameter speed_t      TIMEOUT       = 16'd65535,
  parameter int unsigned GLITCH_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        blink_in,
  output logic [15:0] speed_out,
  output logic        meas_valid,
  output logic        locked,
  output logic        timeout
);

  if (TIMEOUT == 16'd0 || GLITCH_CYCLES == 0) begin : g_param_check
    $error("blink_meter: TIMEOUT and GLITCH_CYCLES must be non-zero");
  end

  logic tic;

  tic_gen #(.TIC_DIV(TIC_DIV)) u_tic_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tic_o (tic)
  );

  logic sync1_q, sync2_q, prev_q, level, edge_det;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= blink_in;
      sync2_q <= sync1_q;
      prev_q  <= level;
    end
  end

`ifdef BLINK_METER_GLITCH_FILTER_EN
  localparam int unsigned GC_W = $clog2(GLITCH_CYCLES + 1);

  logic [GC_W-1:0] stab_q, stab_d;
  logic            filt_q, filt_d;

  // A new level is taken only on the GLITCH_CYCLES-th consecutive differing sample.
  always_comb begin
    filt_d = filt_q;
    stab_d = '0;
    if (sync2_q != filt_q) begin
      if (stab_q == GC_W'(GLITCH_CYCLES - 1)) filt_d = sync2_q;
      else                                    stab_d = stab_q + GC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      stab_q <= '0;
    end else begin
      filt_q <= filt_d;
      stab_q <= stab_d;
    end
  end

  assign level = filt_q;
`else
  assign level = sync2_q;
`endif

  assign edge_det = level ^ prev_q;

  meter_state_t state_q, state_d;
  speed_t       count_q, count_d, speed_q, speed_d;
  logic         valid_q, valid_d, locked_q, locked_d, timeout_q, timeout_d;
  logic [16:0]  m;
  logic         m_nz, m_to;

  // The tic of the current cycle is always part of the measurement, even on an edge.
  assign m    = {1'b0, count_q} + 17'(tic);
  assign m_nz = (m != 17'd0);
  assign m_to = (m >= {1'b0, TIMEOUT});

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    count_d   = count_q;
    speed_d   = speed_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        count_d = '0;
        if (edge_det) state_d = ARMED;
      end
      ARMED, TRACK: begin
        count_d = m_to ? TIMEOUT : m[15:0];
        if (edge_det) begin
          count_d = '0;
          if (m_nz) begin
            speed_d  = m[15:0];
            valid_d  = 1'b1;
            locked_d = (state_q == TRACK) && (m[15:0] == speed_q);
            state_d  = TRACK;
          end else if (state_q == TRACK) begin
            locked_d = 1'b0;
          end
        end else if (m_to) begin
          count_d   = '0;
          speed_d   = '0;
          locked_d  = 1'b0;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      speed_q   <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      speed_q   <= speed_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
    end
  end

  assign speed_out  = speed_q;
  assign meas_valid = valid_q;
  assign locked     = locked_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_blink_meter.sv
// Directed bench for blink_meter (TIC_DIV=4, TIMEOUT=10, filter disabled); cycle k has prescaler phase k%4, tic when 3.
module tb_blink_meter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        blink_in;
  logic [15:0] speed_out;
  logic        meas_valid, locked, timeout;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  blink_meter #(
    .TIC_DIV       (4),
    .TIMEOUT       (16'd10),
    .GLITCH_CYCLES (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .blink_in   (blink_in),
    .speed_out  (speed_out),
    .meas_valid (meas_valid),
    .locked     (locked),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [15:0] sp, input logic v,
                           input logic lk, input logic to);
    check({tag, ".speed"},   speed_out,          sp);
    check({tag, ".valid"},   {15'd0, meas_valid}, {15'd0, v});
    check({tag, ".locked"},  {15'd0, locked},     {15'd0, lk});
    check({tag, ".timeout"}, {15'd0, timeout},    {15'd0, to});
  endtask

  initial begin
    rst_n    = 1'b0;
    blink_in = 1'b0;
    repeat (3) @(negedge clk);
    check_out("reset", 16'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc   = 0;

    // Steady blink, 20 clk per half-period; edges land on cycles 7, 27, 47.
    run_to(5);   blink_in = 1'b1;
    run_to(8);   check_out("edge1_arm", 16'd0, 1'b0, 1'b0, 1'b0);
    run_to(25);  blink_in = 1'b0;
    run_to(28);  check_out("edge2_meas", 16'd5, 1'b1, 1'b0, 1'b0);
    run_to(29);  check_out("valid_pulse", 16'd5, 1'b0, 1'b0, 1'b0);
    run_to(45);  blink_in = 1'b1;
    run_to(48);  check_out("edge3_lock", 16'd5, 1'b1, 1'b1, 1'b0);

    // Hold steady: the tenth tic after edge 47 is at cycle 87.
    run_to(87);  check_out("pre_timeout", 16'd5, 1'b0, 1'b1, 1'b0);
    run_to(88);  check_out("timeout", 16'd0, 1'b0, 1'b0, 1'b1);
    run_to(89);  check_out("timeout_pulse", 16'd0, 1'b0, 1'b0, 1'b0);
    run_to(93);  blink_in = 1'b0;
    run_to(96);  check_out("idle_rearm", 16'd0, 1'b0, 1'b0, 1'b0);
    run_to(113); blink_in = 1'b1;
    run_to(116); check_out("armed_meas", 16'd5, 1'b1, 1'b0, 1'b0);

    // Edge on cycle 131 (tic) with count=3.
    run_to(129); blink_in = 1'b0;
    run_to(132); check_out("coincident", 16'd4, 1'b1, 1'b0, 1'b0);

    // Three tics counted (135, 139, 143) when reset is pulsed.
    run_to(145); rst_n = 1'b0;
    step();      rst_n = 1'b1;
    check_out("rst_mid", 16'd0, 1'b0, 1'b0, 1'b0);
    cyc = 0;
    run_to(5);   blink_in = 1'b1;
    run_to(8);   check_out("rst_arm", 16'd0, 1'b0, 1'b0, 1'b0);
    run_to(25);  blink_in = 1'b0;
    run_to(28);  check_out("rst_meas", 16'd5, 1'b1, 1'b0, 1'b0);
    run_to(45);  blink_in = 1'b1;
    run_to(48);  check_out("rst_lock", 16'd5, 1'b1, 1'b1, 1'b0);

    // Falling edge on 67, then a 2-clk high pulse with edges on 68 and 70 (m=0).
    run_to(65);  blink_in = 1'b0;
    run_to(66);  blink_in = 1'b1;
    run_to(68);  check_out("lock_hold", 16'd5, 1'b1, 1'b1, 1'b0);
    blink_in = 1'b0;
    run_to(69);  check_out("glitch_rise", 16'd5, 1'b0, 1'b0, 1'b0);
    run_to(71);  check_out("glitch_fall", 16'd5, 1'b0, 1'b0, 1'b0);

    // Loopback from a speed-7 generator: edge 75 (tics 71,75), then 28-clk half-periods.
    run_to(73);  blink_in = 1'b1;
    run_to(76);  check_out("loop_first", 16'd2, 1'b1, 1'b0, 1'b0);
    run_to(101); blink_in = 1'b0;
    run_to(104); check_out("loop_meas", 16'd7, 1'b1, 1'b0, 1'b0);
    run_to(129); blink_in = 1'b1;
    run_to(132); check_out("loop_lock", 16'd7, 1'b1, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/blink_meter.md
Name: blink_meter

Overview:
Receive-side counterpart of the LED blink generator. The block samples a blink waveform from a pin or loopback and measures its half-period in millisecond tics. It reports the result as a 16-bit speed value on the same scale the generator accepts, so `speed_out` fed back to a generator reproduces the measured blink. It sits beside the blink generator for self-test and loopback, and on board inputs that monitor external indicators.

Parameters:
- TIC_DIV, 100000: clk cycles per 1 ms tic (100 MHz clock).
- TIMEOUT, 16'd65535: tics without an edge before the input is declared steady; must be in range 1..65535.
- GLITCH_CYCLES, 4: clocks of stability required by the glitch filter; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-low.
- blink_in  in  1  asynchronous blink waveform.
- speed_out  out  16  last valid half-period in tics; 0 means no blink.
- meas_valid  out  1  one-cycle pulse when speed_out is updated with a new measurement.
- locked  out  1  high while the two most recent measurements are equal.
- timeout  out  1  one-cycle pulse when TIMEOUT expires.

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low. All state updates on posedge clk.
- Reset (rst_n=0 at a posedge):
  - speed_out=0, meas_valid=0, locked=0, timeout=0.
  - State=IDLE; tic prescaler=0; period count=0; synchronizer flops=0.
  - Reset asserted mid-measurement discards the partial count, with no valid pulse.
- Input conditioning:
  - 2-flop synchronizer, then an edge-detect register.
  - An edge is any change of the synchronized level.
  - meas_valid rises at the 3rd posedge after blink_in settles; this assumes blink_in meets setup for the first flop.
- Tic: prescaler counts 0..TIC_DIV-1 and pulses tic for one clk when it wraps.
- Period count: 16-bit.
  - Increments on tic in ARMED and TRACK.
  - Saturates at TIMEOUT.
  - Cleared on every accepted edge.
- Measurement value m = count + tic. When a tic and an edge occur in the same cycle, the tic is included.
- FSM states and transitions:
  - IDLE: count held at 0. Edge -> ARMED, count=0.
  - ARMED (first edge seen, nothing measured yet):
    - Edge with m>0 -> speed_out=m, meas_valid=1, locked=0, go to TRACK.
    - Edge with m=0 -> glitch: count=0, stay in ARMED, no pulse.
  - TRACK:
    - Edge with m>0 -> speed_out=m, meas_valid=1, locked=(m==previous speed_out), stay in TRACK.
    - Edge with m=0 -> glitch: count=0, locked=0, no pulse.
  - Timeout: in ARMED or TRACK, when m reaches TIMEOUT with no edge in that cycle -> timeout=1, speed_out=0, locked=0, go to IDLE. No meas_valid pulse.
  - Edge and timeout in the same cycle: the edge wins; measure m (=TIMEOUT) normally.
- Round trip: a generator at speed S produces a half-period of S tics, and this block reports speed_out=S.
- Width rule: m never exceeds TIMEOUT ≤ 65535, so no overflow logic is needed beyond saturation.

Optional Feature:
- BLINK_METER_GLITCH_FILTER_EN defined:
  - The synchronized level is accepted only after GLITCH_CYCLES consecutive equal samples.
  - Pulses shorter than that are ignored entirely.
  - Edge latency grows by GLITCH_CYCLES clocks.
- Undefined: 2-flop synchronizer only; every synchronized change is an edge.

Decomposition:
- Package blink_pkg holds:
  - state enum typedef meter_state_t (IDLE, ARMED, TRACK);
  - constant MS_DIV_100MHZ=100000;
  - typedef speed_t = logic [15:0], shared with the generator's speed input.
- One sub-module, tic_gen: parameterised prescaler (TIC_DIV) with clk and rst_n inputs and a one-cycle tic output, reusable by other ms-based blocks.

Test Plan (TIC_DIV=4, TIMEOUT=10, GLITCH_CYCLES=4):
- Steady blink: blink_in toggles every 20 clk (5 tics), phase-aligned to the prescaler.
  - First edge gives no pulse.
  - Second edge gives meas_valid with speed_out=5, locked=0.
  - Third edge gives speed_out=5, locked=1.
- Loopback: connect the generator at speed=7 to blink_in -> speed_out=7 and locked=1 within 3 edges.
- Timeout: after a lock at 5, hold blink_in constant -> timeout pulse 10 tics after the last edge, then speed_out=0, locked=0, state IDLE. A following edge returns to ARMED with no meas_valid.
- Coincident tic/edge: place an edge on the cycle tic fires with count=3 -> speed_out=4.
- Reset mid-measurement: assert rst_n=0 for 1 clk while 3 tics have been counted in TRACK.
  - All outputs are 0 on the next cycle.
  - The next edge only arms; no meas_valid.
- Glitch: 2-clk high pulse during a stable low.
  - Filter on: no effect, and locked stays 1.
  - Filter off: each edge of the pulse is an edge with m=0; the first clears the count and locked, and neither raises meas_valid.
